regfile_writeback_sb: RTL and testbench

//  Write side of the register file: 31 writable 32-bit GPRs ($R1..$R31) with $R0

---
 rtl/regfile_writeback_sb_pkg.sv | 6 +
 rtl/regfile_writeback_sb_scoreboard.sv | 54 +++++
 rtl/regfile_writeback_sb.sv | 68 ++++++
 tb/tb_regfile_writeback_sb.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_sb_pkg.sv
// Shared constants for the GPR file and its write-back scoreboard.
package regfile_writeback_sb_pkg;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_writeback_sb_scoreboard.sv
// Busy-bit scoreboard: one reservation bit per GPR, set at issue, cleared at write-back.
module reg_scoreboard
  import regfile_writeback_sb_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] awr_i,
  input  logic              iss_en_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  input  logic [ADDR_W-1:0] ard1_i,
  input  logic [ADDR_W-1:0] ard2_i,
  output logic              busy1_o,
  output logic              busy2_o,
  output logic              issue_err_o
);
  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_d;
  logic            wr_valid, iss_valid;

  assign wr_valid  = wr_en_i && (awr_i != ZERO);
  assign iss_valid = iss_en_i && (iss_addr_i != ZERO);

  // Clear first so a same-cycle issue to the retiring register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_valid)  busy_d[awr_i]      = 1'b0;
    if (iss_valid) busy_d[iss_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
    err_d = iss_valid && busy_q[iss_addr_i] && !(wr_en_i && (awr_i == iss_addr_i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    busy1_o = rst_n && busy_q[ard1_i] && !(wr_en_i && (awr_i == ard1_i));
    busy2_o = rst_n && busy_q[ard2_i] && !(wr_en_i && (awr_i == ard2_i));
  end

  assign issue_err_o = err_q;
endmodule

// File: rtl/regfile_writeback_sb.sv
// GPR file: $R0 hardwired to zero, two bypassed read ports, busy-bit scoreboard.
module regfile_writeback_sb
  import regfile_writeback_sb_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] Ard1,
  input  logic [ADDR_W-1:0] Ard2,
  output logic [DATA_W-1:0] Dout1,
  output logic [DATA_W-1:0] Dout2,
  output logic              Busy1,
  output logic              Busy2,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] Awr,
  input  logic [DATA_W-1:0] Din,
  input  logic              IssueEn,
  input  logic [ADDR_W-1:0] IssueAddr,
  output logic              IssueErr
);
  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (WrEn && (Awr != ZERO)) begin
      regs_q[Awr] <= Din;
    end
  end

  // Outputs are forced to zero while in reset, even if a write is presented.
  always_comb begin
    Dout1 = '0;
    if (Rst_n && (Ard1 != ZERO)) begin
      if (WrEn && (Awr == Ard1)) Dout1 = Din;
      else                       Dout1 = regs_q[Ard1];
    end
  end

  always_comb begin
    Dout2 = '0;
    if (Rst_n && (Ard2 != ZERO)) begin
      if (WrEn && (Awr == Ard2)) Dout2 = Din;
      else                       Dout2 = regs_q[Ard2];
    end
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .wr_en_i     (WrEn),
    .awr_i       (Awr),
    .iss_en_i    (IssueEn),
    .iss_addr_i  (IssueAddr),
    .ard1_i      (Ard1),
    .ard2_i      (Ard2),
    .busy1_o     (Busy1),
    .busy2_o     (Busy2),
    .issue_err_o (IssueErr)
  );
endmodule

// File: tb/tb_regfile_writeback_sb.sv
// Bench for regfile_writeback_sb: vector table through a scoreboard queue plus reset sequences.
module tb_regfile_writeback_sb;
  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [4:0]  Ard1, Ard2, Awr, IssueAddr;
  logic [31:0] Dout1, Dout2, Din;
  logic        Busy1, Busy2, WrEn, IssueEn, IssueErr;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  regfile_writeback_sb #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Ard1      (Ard1),
    .Ard2      (Ard2),
    .Dout1     (Dout1),
    .Dout2     (Dout2),
    .Busy1     (Busy1),
    .Busy2     (Busy2),
    .WrEn      (WrEn),
    .Awr       (Awr),
    .Din       (Din),
    .IssueEn   (IssueEn),
    .IssueAddr (IssueAddr),
    .IssueErr  (IssueErr)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  awr;
    logic [31:0] din;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
    logic        eerr;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
    logic        eerr;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [4:0] awr, input logic [31:0] din,
                              input logic iss, input logic [4:0] ia,
                              input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic eb1, input logic eb2, input logic eerr);
    vec_t v;
    v.wr = wr; v.awr = awr; v.din = din; v.iss = iss; v.ia = ia;
    v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2; v.eerr = eerr;
    return v;
  endfunction

  task automatic drive(input logic wr, input logic [4:0] awr, input logic [31:0] din,
                       input logic iss, input logic [4:0] ia,
                       input logic [4:0] a1, input logic [4:0] a2);
    WrEn = wr; Awr = awr; Din = din; IssueEn = iss; IssueAddr = ia; Ard1 = a1; Ard2 = a2;
  endtask

  // Inputs change at negedge; combinational outputs sampled 1 ns later,
  // IssueErr sampled 1 ns after the following posedge.
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    @(negedge Clk);
    drive(v.wr, v.awr, v.din, v.iss, v.ia, v.a1, v.a2);
    sbq.push_back('{idx, v.e1, v.e2, v.eb1, v.eb2, v.eerr});
    #1;
    e = sbq.pop_front();
    chk($sformatf("v%0d_dout1", e.idx), Dout1, e.e1);
    chk($sformatf("v%0d_dout2", e.idx), Dout2, e.e2);
    chk($sformatf("v%0d_busy1", e.idx), {31'd0, Busy1}, {31'd0, e.eb1});
    chk($sformatf("v%0d_busy2", e.idx), {31'd0, Busy2}, {31'd0, e.eb2});
    @(posedge Clk);
    #1;
    chk($sformatf("v%0d_issueerr", e.idx), {31'd0, IssueErr}, {31'd0, e.eerr});
  endtask

  initial begin
    //          wr awr   din           iss ia    a1     a2     e1            e2            b1 b2 err
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd5,  32'h0,        32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 5'd0,  32'hDEADBEEF, 0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 5'd7,  32'h12345678, 0, 5'd0,  5'd7,  5'd7,  32'h12345678, 32'h12345678, 0, 0, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  5'd7,  5'd8,  32'h12345678, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,        1, 5'd3,  5'd7,  5'd3,  32'h12345678, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  5'd7,  5'd3,  32'h12345678, 32'h0,        0, 1, 0));
    tbl.push_back(mk(1, 5'd3,  32'h5,        0, 5'd0,  5'd3,  5'd3,  32'h5,        32'h5,        0, 0, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  5'd3,  5'd3,  32'h5,        32'h5,        0, 0, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,        1, 5'd9,  5'd9,  5'd3,  32'h0,        32'h5,        0, 0, 0));
    tbl.push_back(mk(1, 5'd9,  32'h99,       1, 5'd9,  5'd9,  5'd9,  32'h99,       32'h99,       0, 0, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  5'd9,  5'd3,  32'h99,       32'h5,        1, 0, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,        1, 5'd9,  5'd9,  5'd0,  32'h99,       32'h0,        1, 0, 1));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  5'd9,  5'd9,  32'h99,       32'h99,       1, 1, 0));
    tbl.push_back(mk(1, 5'd9,  32'h1,        0, 5'd0,  5'd9,  5'd3,  32'h1,        32'h5,        0, 0, 0));
    tbl.push_back(mk(1, 5'd20, 32'hCAFEF00D, 0, 5'd0,  5'd20, 5'd9,  32'hCAFEF00D, 32'h1,        0, 0, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,        1, 5'd0,  5'd0,  5'd20, 32'h0,        32'hCAFEF00D, 0, 0, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,        1, 5'd0,  5'd9,  5'd0,  32'h1,        32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 5'd31, 32'hFFFFFFFF, 1, 5'd31, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,        1, 5'd31, 5'd30, 5'd31, 32'h0,        32'hFFFFFFFF, 0, 1, 1));
    tbl.push_back(mk(1, 5'd31, 32'h0,        0, 5'd0,  5'd31, 5'd31, 32'h0,        32'h0,        0, 0, 0));

    Rst_n = 1'b0;
    drive(1'b1, 5'd5, 32'h0BADF00D, 1'b1, 5'd5, 5'd5, 5'd5);
    #1;
    chk("rst_bypass_dout1", Dout1, 32'h0);
    chk("rst_bypass_dout2", Dout2, 32'h0);
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_hold_dout1", Dout1, 32'h0);
    chk("rst_hold_busy1", {31'd0, Busy1}, 32'h0);
    chk("rst_hold_issueerr", {31'd0, IssueErr}, 32'h0);
    @(negedge Clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    Rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      @(negedge Clk);
      Ard1 = 5'(i);
      Ard2 = 5'(31 - i);
      #1;
      chk($sformatf("rst_read_dout1_a%0d", i), Dout1, 32'h0);
      chk($sformatf("rst_read_dout2_a%0d", 31 - i), Dout2, 32'h0);
      chk($sformatf("rst_read_busy1_a%0d", i), {31'd0, Busy1}, 32'h0);
      chk($sformatf("rst_read_busy2_a%0d", 31 - i), {31'd0, Busy2}, 32'h0);
    end

    for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

    // Mid-cycle asynchronous reset discards $R4 contents and its reservation.
    @(negedge Clk);
    drive(1'b1, 5'd4, 32'hA5A5A5A5, 1'b1, 5'd4, 5'd4, 5'd4);
    @(negedge Clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4);
    #1;
    chk("r4_before_rst_dout1", Dout1, 32'hA5A5A5A5);
    chk("r4_before_rst_busy2", {31'd0, Busy2}, 32'h1);
    #1;
    Rst_n = 1'b0;
    #1;
    chk("r4_async_rst_dout1", Dout1, 32'h0);
    chk("r4_async_rst_dout2", Dout2, 32'h0);
    chk("r4_async_rst_busy1", {31'd0, Busy1}, 32'h0);
    chk("r4_async_rst_busy2", {31'd0, Busy2}, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    chk("r4_after_rst_dout1", Dout1, 32'h0);
    chk("r4_after_rst_busy1", {31'd0, Busy1}, 32'h0);
    @(negedge Clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd0);
    @(posedge Clk);
    #1;
    chk("r4_reissue_no_err", {31'd0, IssueErr}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
